ex_muldiv: RTL and testbench

EX-stage multiply/divide unit with the architectural HI/LO registers. It consumes the mult, div, mdsign, A, B, hiloren and hilowen fields that the ID/EX segment register holds for the instruction in EX. Multi-cycle operations request a pipeline stall so that the ID/EX register holds the instruction until the result is ready. HI/LO commit when the owning instruction leaves EX.

---
 rtl/ex_muldiv_pkg.sv | 21 ++
 rtl/ex_muldiv_div_radix2.sv | 72 +++++++
 rtl/ex_muldiv.sv | 127 ++++++++++++
 tb/tb_ex_muldiv.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared state encoding, HI/LO select indices and a sign helper
// for the EX-stage multiply/divide unit.
`default_nettype none
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int HI_BIT = 1;
  localparam int LO_BIT = 0;

  // Two's-complement negate when neg is set; serves both magnitude and sign fix-up.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_div_radix2.sv
// div_radix2: iterative restoring divider, one quotient bit per cycle on operand
// magnitudes, with sign pre- and post-correction.
`default_nettype none
module div_radix2
  import ex_muldiv_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        sign_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [5:0]  iter_q;
  logic        run_q;
  logic        qneg_q;
  logic        rneg_q;

  logic [32:0] shifted_d;
  logic [32:0] diff_d;

  assign shifted_d = {rem_q, quo_q[31]};
  assign diff_d    = shifted_d - {1'b0, dvs_q};

  // High during the cycle whose closing edge performs the final iteration.
  assign done_o = run_q && (iter_q == 6'(ITERS - 1));
  assign quot_o = mag32(quo_q, qneg_q);
  assign rem_o  = mag32(rem_q, rneg_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= mag32(a_i, sign_i && a_i[31]);
      dvs_q  <= mag32(b_i, sign_i && b_i[31]);
      iter_q <= '0;
      run_q  <= 1'b1;
      qneg_q <= sign_i && (a_i[31] ^ b_i[31]);
      rneg_q <= sign_i && a_i[31];
    end else if (run_q) begin
      if (!diff_d[32]) begin
        rem_q <= diff_d[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted_d[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      iter_q <= iter_q + 6'd1;
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply/divide unit owning the HI/LO registers; stalls the
// pipeline while an operation is in flight and commits when the instruction leaves EX.
`default_nettype none
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refresh,
  input  logic        stall_in,
  input  logic        ex_mult,
  input  logic        ex_div,
  input  logic        ex_mdsign,
  input  logic [31:0] ex_A,
  input  logic [31:0] ex_B,
  input  logic [1:0]  ex_hiloren,
  input  logic [1:0]  ex_hilowen,
  output logic        md_stall,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  generate
    if (DIV_ITER != 32) begin : g_div_iter_chk
      $error("ex_muldiv: DIV_ITER must be 32");
    end
    if (MUL_LAT < 1 || MUL_LAT > 255) begin : g_mul_lat_chk
      $error("ex_muldiv: MUL_LAT must be in 1..255");
    end
  endgenerate

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        is_div_q;
  logic [63:0] prod_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        req_d;
  logic        div_start_d;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [63:0] prod_d;
  logic [31:0] res_hi_d;
  logic [31:0] res_lo_d;

  assign req_d       = (ex_mult || ex_div) && !refresh;
  assign div_start_d = (state_q == IDLE) && ex_div && !refresh;

  // Sign-extending to 64 bits lets one unsigned multiply cover MULT and MULTU.
  assign prod_d = {{32{ex_mdsign & ex_A[31]}}, ex_A} * {{32{ex_mdsign & ex_B[31]}}, ex_B};

  assign res_hi_d = is_div_q ? div_rem  : prod_q[63:32];
  assign res_lo_d = is_div_q ? div_quot : prod_q[31:0];

  assign md_stall = !reset && !refresh &&
                    ((state_q == BUSY) || ((state_q == IDLE) && (ex_mult || ex_div)));

  assign hi = hi_q;
  assign lo = lo_q;
  assign hilo_rdata = ex_hiloren[HI_BIT] ? hi_q :
                      ex_hiloren[LO_BIT] ? lo_q : 32'd0;

  div_radix2 #(
    .ITERS (DIV_ITER)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start_i (div_start_d),
    .sign_i  (ex_mdsign),
    .a_i     (ex_A),
    .b_i     (ex_B),
    .done_o  (div_done),
    .quot_o  (div_quot),
    .rem_o   (div_rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      prod_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (refresh) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_d) begin
            is_div_q <= ex_div;
            prod_q   <= prod_d;
            cnt_q    <= '0;
            state_q  <= (ex_div || MUL_LAT > 1) ? BUSY : DONE;
          end else if (!stall_in) begin
            if (ex_hilowen[HI_BIT]) hi_q <= ex_A;
            if (ex_hilowen[LO_BIT]) lo_q <= ex_A;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          if (is_div_q ? div_done : (cnt_q == 8'(MUL_LAT - 2))) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // The owning instruction leaves EX on this same edge, so IDLE cannot retrigger on it.
          if (!stall_in) begin
            hi_q    <= res_hi_d;
            lo_q    <= res_lo_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv with directed corner cases and
// randomized MULT/DIV traffic checked against a plain-arithmetic reference model.
`timescale 1ns/1ps
`default_nettype none
module tb_ex_muldiv;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        refresh = 1'b0;
  logic        stall_in = 1'b0;
  logic        ex_mult = 1'b0;
  logic        ex_div = 1'b0;
  logic        ex_mdsign = 1'b0;
  logic [31:0] ex_A = '0;
  logic [31:0] ex_B = '0;
  logic [1:0]  ex_hiloren = '0;
  logic [1:0]  ex_hilowen = '0;
  logic        md_stall;
  logic [31:0] hilo_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb_q[$];
  event ev_out;

  always #5 clk = ~clk;

  ex_muldiv #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .refresh    (refresh),
    .stall_in   (stall_in),
    .ex_mult    (ex_mult),
    .ex_div     (ex_div),
    .ex_mdsign  (ex_mdsign),
    .ex_A       (ex_A),
    .ex_B       (ex_B),
    .ex_hiloren (ex_hiloren),
    .ex_hilowen (ex_hilowen),
    .md_stall   (md_stall),
    .hilo_rdata (hilo_rdata),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {HI, LO} from architectural arithmetic on 64-bit integers.
  function automatic logic [63:0] ref_md(input bit is_div, input bit s,
                                         input logic [31:0] a, input logic [31:0] b);
    longint la, lb, p;
    la = s ? longint'($signed(a)) : longint'({32'd0, a});
    lb = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (!is_div) begin
      p = la * lb;
      return 64'(p);
    end
    if (b == 32'd0) return {a, (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF};
    return {32'(la % lb), 32'(la / lb)};
  endfunction

  // Monitor: compares the architectural registers whenever an instruction commits.
  initial begin : monitor
    exp_t e;
    forever begin
      @(ev_out);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: commit with no expected entry");
      end else begin
        e = sb_q.pop_front();
        check32("commit_hi", hi, e.hi);
        check32("commit_lo", lo, e.lo);
      end
    end
  end

  task automatic run_op(input bit is_div, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [63:0] r;
    int n;
    r = ref_md(is_div, s, a, b);
    n = 0;
    @(negedge clk);
    ex_mult = !is_div; ex_div = is_div; ex_mdsign = s; ex_A = a; ex_B = b;
    stall_in = (hold > 0);
    #1;
    while (md_stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check32(is_div ? "div_stall_len" : "mul_stall_len", 32'(n), is_div ? 32'd33 : 32'(MUL_LAT));
    sb_q.push_back('{r[63:32], r[31:0]});
    repeat (hold) begin
      @(posedge clk);
      #1;
      check32("held_hi", hi, m_hi);
      check32("held_lo", lo, m_lo);
      check32("held_stall", 32'(md_stall), 32'd0);
    end
    stall_in = 1'b0;
    @(posedge clk);
    #1;
    ex_mult = 1'b0; ex_div = 1'b0;
    m_hi = r[63:32]; m_lo = r[31:0];
    -> ev_out;
  endtask

  task automatic mt(input logic [1:0] wen, input logic [31:0] a, input bit blocked);
    @(negedge clk);
    ex_hilowen = wen; ex_A = a; stall_in = blocked;
    if (!blocked && wen[1]) m_hi = a;
    if (!blocked && wen[0]) m_lo = a;
    sb_q.push_back('{m_hi, m_lo});
    @(posedge clk);
    #1;
    ex_hilowen = 2'b00; stall_in = 1'b0;
    -> ev_out;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin : driver
    repeat (3) @(negedge clk);
    #1;
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    check32("reset_stall", 32'(md_stall), 32'd0);
    reset = 1'b0;

    // Directed cases
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    @(negedge clk);
    ex_hiloren = 2'b01; #1; check32("mflo", hilo_rdata, 32'hFFFF_FFFD);
    ex_hiloren = 2'b10; #1; check32("mfhi", hilo_rdata, 32'hFFFF_FFFF);
    ex_hiloren = 2'b00; #1; check32("mf_none", hilo_rdata, 32'd0);
    run_op(1'b1, 1'b0, 32'd100, 32'd0, 0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0, 0);

    // Flush in flight at iteration 10, then an immediate MULT
    @(negedge clk);
    ex_div = 1'b1; ex_mdsign = 1'b0; ex_A = 32'd12345; ex_B = 32'd7;
    repeat (11) @(negedge clk);
    #1; check32("busy_before_flush", 32'(md_stall), 32'd1);
    refresh = 1'b1;
    #1; check32("flush_stall", 32'(md_stall), 32'd0);
    @(posedge clk);
    #1; refresh = 1'b0; ex_div = 1'b0;
    @(negedge clk);
    #1;
    check32("post_flush_stall", 32'(md_stall), 32'd0);
    check32("post_flush_hi", hi, m_hi);
    check32("post_flush_lo", lo, m_lo);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 0);

    // Flush in the start cycle
    @(negedge clk);
    ex_mult = 1'b1; refresh = 1'b1; ex_A = 32'd9; ex_B = 32'd9;
    #1; check32("start_flush_stall", 32'(md_stall), 32'd0);
    @(posedge clk);
    #1; ex_mult = 1'b0; refresh = 1'b0;
    @(negedge clk);
    #1; check32("killed_start_stall", 32'(md_stall), 32'd0);

    // Commit held off by stall_in for three DONE cycles
    run_op(1'b0, 1'b0, 32'h0001_0000, 32'h0003_0000, 3);

    mt(2'b10, 32'h1234_5678, 1'b0);
    mt(2'b01, 32'h9ABC_DEF0, 1'b0);
    mt(2'b11, 32'h5555_AAAA, 1'b1);
    mt(2'b11, 32'h0BAD_F00D, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pick(), pick(),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    // Asynchronous reset in the middle of a division
    mt(2'b11, 32'hCAFE_0001, 1'b0);
    @(negedge clk);
    ex_div = 1'b1; ex_A = 32'd1000; ex_B = 32'd3;
    repeat (5) @(negedge clk);
    #2; reset = 1'b1;
    #1;
    check32("async_reset_hi", hi, 32'd0);
    check32("async_reset_lo", lo, 32'd0);
    check32("async_reset_stall", 32'(md_stall), 32'd0);
    ex_div = 1'b0; m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b1, 1'b0, 32'd1000, 32'd3, 0);

    repeat (3) @(negedge clk);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
